// File: rtl/accel_status_pkg.sv
// ============================================================================
//  Module      : accel_status_pkg
//  Description : Shared types and STATUS_0 field widths for the packet
//                status controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package accel_status_pkg;

  localparam int ID_W      = 6;
  localparam int CNT_W     = 10;
  localparam int BUF_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  typedef struct packed {
    logic [ID_W-1:0]      id;
    logic [BUF_CNT_W-1:0] buffered_ids;
    logic                 err_buffer;
    logic                 err_packet;
    logic                 err_clear;
    logic [CNT_W-1:0]     packet_count;
  } status_fields_t;

endpackage

`default_nettype wire

// File: rtl/packet_id_fifo.sv
// ============================================================================
//  Module      : packet_id_fifo
//  Description : Synchronous FIFO with occupancy count, full and empty flags.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module packet_id_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // A pop frees the slot on the same edge, so a push into a full FIFO is legal then.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/packet_status_ctrl.sv
// ============================================================================
//  Module      : packet_status_ctrl
//  Description : Issues queued packet IDs one at a time to the datapath and
//                produces the live STATUS_0 field values.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module packet_status_ctrl
  import accel_status_pkg::*;
#(
  parameter int BUF_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_id_valid,
  input  logic [ID_W-1:0]      i_id_data,
  output logic                 o_start_valid,
  input  logic                 i_start_ready,
  output logic [ID_W-1:0]      o_start_id,
  input  logic                 i_done_valid,
  input  logic [ID_W-1:0]      i_done_id,
  input  logic                 i_err_clear_req,
  output logic [ID_W-1:0]      o_status_id,
  output logic [BUF_CNT_W-1:0] o_status_buffered_ids,
  output logic                 o_status_err_buffer,
  output logic                 o_status_err_packet,
  output logic                 o_status_err_clear,
  output logic [CNT_W-1:0]     o_status_packet_count
);

  state_t               r_state;
  logic                 r_start_valid;
  logic [ID_W-1:0]      r_id;
  logic [CNT_W-1:0]     r_count;
  logic                 r_err_buf;
  logic                 r_err_pkt;
  logic                 r_err_clr;

  logic [ID_W-1:0]      w_head;
  logic [BUF_CNT_W-1:0] w_fifo_count;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic                 w_pop;
  logic                 w_err_buf_evt;
  logic                 w_done_good;
  logic                 w_err_pkt_evt;
  status_fields_t       w_status;

  packet_id_fifo #(
    .WIDTH (ID_W),
    .DEPTH (BUF_DEPTH),
    .CNT_W (BUF_CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (i_id_valid),
    .i_data  (i_id_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_pop         = r_start_valid && i_start_ready;
  assign w_err_buf_evt = i_id_valid && w_fifo_full && !w_pop;
  assign w_done_good   = i_done_valid && (r_state == ST_BUSY) && (i_done_id == r_id);
  assign w_err_pkt_evt = i_done_valid && !w_done_good;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_start_valid <= 1'b0;
      r_id          <= '0;
      r_count       <= '0;
    end else begin
      if (w_done_good) r_count <= r_count + CNT_W'(1);
      case (r_state)
        ST_IDLE: begin
          if (!w_fifo_empty) begin
            r_state       <= ST_ISSUE;
            r_start_valid <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (i_start_ready) begin
            r_state       <= ST_BUSY;
            r_start_valid <= 1'b0;
            r_id          <= w_head;
          end
        end
        ST_BUSY: begin
          // Nothing pops in BUSY, so any push this cycle leaves the queue non-empty.
          if (i_done_valid) begin
            if (!w_fifo_empty || i_id_valid) begin
              r_state       <= ST_ISSUE;
              r_start_valid <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_start_valid <= 1'b0;
        end
      endcase
    end
  end

  // A new error on the clear cycle wins and flags the clear as lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_buf <= 1'b0;
      r_err_pkt <= 1'b0;
      r_err_clr <= 1'b0;
    end else if (i_err_clear_req) begin
      r_err_buf <= w_err_buf_evt;
      r_err_pkt <= w_err_pkt_evt;
      r_err_clr <= w_err_buf_evt || w_err_pkt_evt;
    end else begin
      r_err_buf <= r_err_buf || w_err_buf_evt;
      r_err_pkt <= r_err_pkt || w_err_pkt_evt;
    end
  end

  assign w_status = '{
    id:           r_id,
    buffered_ids: w_fifo_count,
    err_buffer:   r_err_buf,
    err_packet:   r_err_pkt,
    err_clear:    r_err_clr,
    packet_count: r_count
  };

  assign o_start_valid         = r_start_valid;
  assign o_start_id            = w_head;
  assign o_status_id           = w_status.id;
  assign o_status_buffered_ids = w_status.buffered_ids;
  assign o_status_err_buffer   = w_status.err_buffer;
  assign o_status_err_packet   = w_status.err_packet;
  assign o_status_err_clear    = w_status.err_clear;
  assign o_status_packet_count = w_status.packet_count;

endmodule

`default_nettype wire

// File: tb/tb_packet_status_ctrl.sv
// ============================================================================
//  Module      : tb_packet_status_ctrl
//  Description : Directed self-checking bench with an issue-order scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_packet_status_ctrl;
  import accel_status_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 i_id_valid;
  logic [ID_W-1:0]      i_id_data;
  logic                 o_start_valid;
  logic                 i_start_ready;
  logic [ID_W-1:0]      o_start_id;
  logic                 i_done_valid;
  logic [ID_W-1:0]      i_done_id;
  logic                 i_err_clear_req;
  logic [ID_W-1:0]      o_status_id;
  logic [BUF_CNT_W-1:0] o_status_buffered_ids;
  logic                 o_status_err_buffer;
  logic                 o_status_err_packet;
  logic                 o_status_err_clear;
  logic [CNT_W-1:0]     o_status_packet_count;

  int              n_pass  = 0;
  int              n_total = 0;
  logic [ID_W-1:0] q_exp[$];
  logic [ID_W-1:0] last_issue = '0;

  packet_status_ctrl #(.BUF_DEPTH(4)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .i_id_valid            (i_id_valid),
    .i_id_data             (i_id_data),
    .o_start_valid         (o_start_valid),
    .i_start_ready         (i_start_ready),
    .o_start_id            (o_start_id),
    .i_done_valid          (i_done_valid),
    .i_done_id             (i_done_id),
    .i_err_clear_req       (i_err_clear_req),
    .o_status_id           (o_status_id),
    .o_status_buffered_ids (o_status_buffered_ids),
    .o_status_err_buffer   (o_status_err_buffer),
    .o_status_err_packet   (o_status_err_packet),
    .o_status_err_clear    (o_status_err_clear),
    .o_status_packet_count (o_status_packet_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_errs(input string tag, input logic b, input logic p, input logic c);
    check({tag, "_err_buffer"}, 32'(o_status_err_buffer), 32'(b));
    check({tag, "_err_packet"}, 32'(o_status_err_packet), 32'(p));
    check({tag, "_err_clear"},  32'(o_status_err_clear),  32'(c));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [ID_W-1:0] id, input bit accept);
    i_id_valid = 1'b1;
    i_id_data  = id;
    if (accept) q_exp.push_back(id);
    tick();
    i_id_valid = 1'b0;
  endtask

  task automatic done(input logic [ID_W-1:0] id);
    i_done_valid = 1'b1;
    i_done_id    = id;
    tick();
    i_done_valid = 1'b0;
  endtask

  task automatic clear_err();
    i_err_clear_req = 1'b1;
    tick();
    i_err_clear_req = 1'b0;
  endtask

  task automatic wait_handshake(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (o_start_valid && i_start_ready) seen = 1'b1;
      tick();
    end
    check({tag, "_handshake"}, 32'(seen), 32'd1);
  endtask

  // Every issue handshake must present the oldest accepted, not-yet-issued ID.
  always @(negedge clk) begin
    if (!rst && o_start_valid && i_start_ready) begin
      n_total++;
      assert (q_exp.size() > 0) begin
        n_pass++;
        last_issue = q_exp.pop_front();
        check("start_id", 32'(o_start_id), 32'(last_issue));
      end else $error("FAIL unexpected_issue: observed start_id 0x%0h, expected no issue", o_start_id);
    end
  end

  initial begin
    rst = 1'b1; i_id_valid = 1'b0; i_id_data = '0; i_start_ready = 1'b1;
    i_done_valid = 1'b0; i_done_id = '0; i_err_clear_req = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_start_valid", 32'(o_start_valid), 32'd0);
    check("rst_status_id", 32'(o_status_id), 32'd0);
    check("rst_buffered", 32'(o_status_buffered_ids), 32'd0);
    check("rst_count", 32'(o_status_packet_count), 32'd0);
    check_errs("rst", 1'b0, 1'b0, 1'b0);

    // Two packets back to back
    push(6'd5, 1'b1);
    push(6'd9, 1'b1);
    check("t1_buffered_2", 32'(o_status_buffered_ids), 32'd2);
    wait_handshake("t1_a");
    check("t1_buffered_1", 32'(o_status_buffered_ids), 32'd1);
    check("t1_status_id_5", 32'(o_status_id), 32'd5);
    done(6'd5);
    wait_handshake("t1_b");
    check("t1_buffered_0", 32'(o_status_buffered_ids), 32'd0);
    done(6'd9);
    check("t1_count", 32'(o_status_packet_count), 32'd2);
    check("t1_status_id_9", 32'(o_status_id), 32'd9);
    check_errs("t1", 1'b0, 1'b0, 1'b0);

    // Overflow drops the fifth ID; a push alongside a pop at full is kept
    i_start_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(6'(10 + i), i < 4);
    check("t2_buffered_full", 32'(o_status_buffered_ids), 32'd4);
    check("t2_err_buffer", 32'(o_status_err_buffer), 32'd1);
    clear_err();
    check_errs("t2_clr", 1'b0, 1'b0, 1'b0);
    i_start_ready = 1'b1;
    push(6'd15, 1'b1);
    check("t2_push_pop_full", 32'(o_status_buffered_ids), 32'd4);
    check("t2_no_drop_err", 32'(o_status_err_buffer), 32'd0);
    done(last_issue);
    for (int i = 0; i < 4; i++) begin
      wait_handshake("t2_drain");
      done(last_issue);
    end
    check("t2_count", 32'(o_status_packet_count), 32'd7);
    check("t2_buffered_0", 32'(o_status_buffered_ids), 32'd0);
    check("t2_sb_empty", 32'(q_exp.size()), 32'd0);

    // Mismatched completion
    push(6'd3, 1'b1);
    wait_handshake("t3");
    done(6'd4);
    check("t3_err_packet", 32'(o_status_err_packet), 32'd1);
    check("t3_count", 32'(o_status_packet_count), 32'd7);
    check("t3_status_id", 32'(o_status_id), 32'd3);
    check("t3_idle", 32'(o_start_valid), 32'd0);
    clear_err();
    check_errs("t3_clr", 1'b0, 1'b0, 1'b0);

    // Completion with nothing in flight
    done(6'd7);
    check("t4_err_packet", 32'(o_status_err_packet), 32'd1);
    check("t4_count", 32'(o_status_packet_count), 32'd7);
    clear_err();
    check_errs("t4_clr", 1'b0, 1'b0, 1'b0);

    // Clear lost to a same-cycle overflow
    i_start_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(6'(20 + i), i < 4);
    i_id_valid = 1'b1; i_id_data = 6'd25; i_err_clear_req = 1'b1;
    tick();
    i_id_valid = 1'b0; i_err_clear_req = 1'b0;
    check_errs("t5_lost", 1'b1, 1'b0, 1'b1);
    check("t5_buffered", 32'(o_status_buffered_ids), 32'd4);
    clear_err();
    check_errs("t5_clr", 1'b0, 1'b0, 1'b0);
    i_start_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_handshake("t5_drain");
      done(last_issue);
    end
    check("t5_count", 32'(o_status_packet_count), 32'd11);
    check("t5_buffered_0", 32'(o_status_buffered_ids), 32'd0);

    // Counter wrap, then asynchronous reset while busy
    rst = 1'b1; q_exp.delete();
    tick();
    rst = 1'b0;
    tick();
    check("t6_rst_count", 32'(o_status_packet_count), 32'd0);
    for (int i = 0; i < 1023; i++) begin
      push(6'(i), 1'b1);
      wait_handshake("t6_loop");
      done(last_issue);
    end
    check("t6_count_max", 32'(o_status_packet_count), 32'd1023);
    push(6'd33, 1'b1);
    wait_handshake("t6_wrap");
    done(last_issue);
    check("t6_count_wrap", 32'(o_status_packet_count), 32'd0);
    check_errs("t6_wrap", 1'b0, 1'b0, 1'b0);
    push(6'd34, 1'b1);
    wait_handshake("t6_one");
    done(last_issue);
    push(6'd40, 1'b1);
    wait_handshake("t6_busy");
    push(6'd41, 1'b1);
    push(6'd42, 1'b1);
    check("t6_pre_id", 32'(o_status_id), 32'd40);
    check("t6_pre_buffered", 32'(o_status_buffered_ids), 32'd2);
    check("t6_pre_count", 32'(o_status_packet_count), 32'd1);
    #2 rst = 1'b1;
    #1;
    q_exp.delete();
    check("t6_async_start_valid", 32'(o_start_valid), 32'd0);
    check("t6_async_id", 32'(o_status_id), 32'd0);
    check("t6_async_buffered", 32'(o_status_buffered_ids), 32'd0);
    check("t6_async_count", 32'(o_status_packet_count), 32'd0);
    check_errs("t6_async", 1'b0, 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    tick();
    done(6'd40);
    check("t6_late_done_err", 32'(o_status_err_packet), 32'd1);
    check("t6_late_done_count", 32'(o_status_packet_count), 32'd0);
    check("t6_late_done_idle", 32'(o_start_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
